icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction unit and the memory arbiter. It answers the instruction unit's fetch (`pc_in`/`inst_req_in`) combinationally on a hit. On a miss it fills the line with four byte reads from the arbiter's byte-wide RAM port. While a fill is in flight it holds `mem_busy_out` high so the instruction unit stops requesting.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 148 ++++++++++++++
 tb/tb_icache.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address helper for the instruction cache.
package icache_pkg;

   localparam int ICACHE_INDEX_BIT_DEF = 8;
   localparam int ICACHE_CNT_BIT       = 3;

   typedef enum logic [1:0] {
      ICACHE_IDLE = 2'd0,
      ICACHE_REQ  = 2'd1,
      ICACHE_READ = 2'd2
   } icache_state_e;

   localparam logic [ICACHE_CNT_BIT-1:0] ICACHE_LAST_CNT = 3'd4;

   // Word-aligned line address; the two byte-offset bits of a fetch are don't-care.
   function automatic logic [31:0] line_addr(input logic [31:0] pc);
      return pc & ~32'h3;
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and arbiter-side signals of the instruction cache.
interface icache_if;

   logic [31:0] pc_in;
   logic        inst_req_in;
   logic        inst_ready_out;
   logic [31:0] inst_out;
   logic        mem_busy_out;

   logic        mem_rd_req_out;
   logic        mem_grant_in;
   logic [31:0] mem_a_out;
   logic [7:0]  mem_din_in;

   modport slave (
      input  pc_in, inst_req_in, mem_grant_in, mem_din_in,
      output inst_ready_out, inst_out, mem_busy_out, mem_rd_req_out, mem_a_out
   );

   modport master (
      output pc_in, inst_req_in, mem_grant_in, mem_din_in,
      input  inst_ready_out, inst_out, mem_busy_out, mem_rd_req_out, mem_a_out
   );

endinterface

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache, filled by four byte reads.
// Optional hit/miss counters are built when ICACHE_STAT_EN is defined.
module icache
   import icache_pkg::*;
#(
   parameter int ICACHE_INDEX_BIT = ICACHE_INDEX_BIT_DEF
) (
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   input  logic     clear_in,
   icache_if.slave  bus
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0] hit_cnt_out,
   output logic [31:0] miss_cnt_out
`endif
);

   localparam int LINES = 1 << ICACHE_INDEX_BIT;
   localparam int TAG_W = 32 - ICACHE_INDEX_BIT - 2;

   icache_state_e             state_q, state_d;
   logic [ICACHE_CNT_BIT-1:0] cnt_q, cnt_d;
   logic [31:0]               buf_q, buf_d;
   logic [31:0]               miss_addr_q, miss_addr_d;

   logic [LINES-1:0]          valid_q;
   logic [TAG_W-1:0]          tag_q  [LINES];
   logic [31:0]               data_q [LINES];

   logic [ICACHE_INDEX_BIT-1:0] idx, fill_idx;
   logic [TAG_W-1:0]            tag_in, fill_tag;
   logic                        hit, miss, fill_we;
   logic [31:0]                 fill_word;

   assign idx      = bus.pc_in[ICACHE_INDEX_BIT+1:2];
   assign tag_in   = bus.pc_in[31:ICACHE_INDEX_BIT+2];
   assign fill_idx = miss_addr_q[ICACHE_INDEX_BIT+1:2];
   assign fill_tag = miss_addr_q[31:ICACHE_INDEX_BIT+2];

   // Lookup is fully combinational so a hit returns in the request cycle.
   assign hit  = bus.inst_req_in && valid_q[idx] && (tag_q[idx] == tag_in);
   assign miss = bus.inst_req_in && !hit && !clear_in;

   // The last byte is still on the RAM bus when the line is written.
   assign fill_word = {bus.mem_din_in, buf_q[23:0]};

   assign bus.inst_ready_out = hit;
   assign bus.inst_out       = hit ? data_q[idx] : 32'd0;
   assign bus.mem_busy_out   = (state_q != ICACHE_IDLE);
   assign bus.mem_rd_req_out = (state_q == ICACHE_REQ) || (state_q == ICACHE_READ);

   always_comb begin
      bus.mem_a_out = 32'd0;
      if (state_q == ICACHE_READ && cnt_q < ICACHE_LAST_CNT) begin
         bus.mem_a_out = miss_addr_q + 32'(cnt_q);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      miss_addr_d = miss_addr_q;
      fill_we     = 1'b0;
      unique case (state_q)
         ICACHE_IDLE: begin
            if (miss) begin
               state_d     = ICACHE_REQ;
               miss_addr_d = line_addr(bus.pc_in);
            end
         end
         ICACHE_REQ: begin
            if (bus.mem_grant_in) begin
               state_d = ICACHE_READ;
               cnt_d   = '0;
            end
         end
         ICACHE_READ: begin
            cnt_d = cnt_q + ICACHE_CNT_BIT'(1);
            // Each byte arrives one cycle after its address, so cnt lags by one.
            case (cnt_q)
               3'd1: buf_d[7:0]   = bus.mem_din_in;
               3'd2: buf_d[15:8]  = bus.mem_din_in;
               3'd3: buf_d[23:16] = bus.mem_din_in;
               3'd4: begin
                  buf_d[31:24] = bus.mem_din_in;
                  fill_we      = 1'b1;
                  state_d      = ICACHE_IDLE;
                  cnt_d        = '0;
               end
               default: ;
            endcase
         end
         default: state_d = ICACHE_IDLE;
      endcase
      // A flush abandons any fill in flight; the partial line is never written.
      if (clear_in) begin
         state_d = ICACHE_IDLE;
         cnt_d   = '0;
         fill_we = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= ICACHE_IDLE;
         cnt_q       <= '0;
         buf_q       <= '0;
         miss_addr_q <= '0;
         valid_q     <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         miss_addr_q <= miss_addr_d;
         if (fill_we) begin
            valid_q[fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data storage needs no reset; valid_q gates every read of it.
   always_ff @(posedge clk_in) begin
      if (rdy_in && fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= fill_word;
      end
   end

`ifdef ICACHE_STAT_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         hit_cnt_out  <= 32'd0;
         miss_cnt_out <= 32'd0;
      end else if (rdy_in) begin
         if (hit) begin
            hit_cnt_out <= hit_cnt_out + 32'd1;
         end
         if (state_q == ICACHE_IDLE && state_d == ICACHE_REQ) begin
            miss_cnt_out <= miss_cnt_out + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: byte RAM and arbiter models, vector table of fetches, hand-written corner sequences.
module tb_icache;
   import icache_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic clear_in;
   icache_if bus();

`ifdef ICACHE_STAT_EN
   logic [31:0] hit_cnt_out, miss_cnt_out;
`endif

   icache #(.ICACHE_INDEX_BIT(8)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .clear_in (clear_in),
      .bus      (bus)
`ifdef ICACHE_STAT_EN
      ,
      .hit_cnt_out  (hit_cnt_out),
      .miss_cnt_out (miss_cnt_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   logic [7:0]  ram [4096];
   logic [31:0] exp_q [$];
   int          grant_delay;
   int          wait_cnt;

   // Byte RAM: data appears one cycle after its address, frozen with rdy_in.
   always @(posedge clk_in) begin
      if (rdy_in) bus.mem_din_in <= ram[bus.mem_a_out[11:0]];
   end

   // Arbiter: grants after grant_delay cycles of request, then holds grant.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) wait_cnt <= 0;
      else if (rdy_in) begin
         if (!bus.mem_rd_req_out) wait_cnt <= 0;
         else if (wait_cnt < grant_delay) wait_cnt <= wait_cnt + 1;
      end
   end
   assign bus.mem_grant_in = bus.mem_rd_req_out && (wait_cnt >= grant_delay);

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      logic [11:0] b;
      b = {a[11:2], 2'b00};
      return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      int          gdel;
      bit          miss;
      int          pen;
      logic [31:0] word;
   } vec_t;

   vec_t vecs [12];

   task automatic do_fetch(input logic [31:0] pc, input int gdel, input bit exp_miss,
                           input int exp_pen, input logic [31:0] exp_word, input string name);
      logic [31:0] trace [$];
      logic [31:0] exp_tr [$];
      logic [31:0] w;
      int  busy_n = 0;
      bit  got = 1'b0, missed = 1'b0, inst_leak = 1'b0, req_bad = 1'b0, tr_ok;
      grant_delay = gdel;
      @(negedge clk_in);
      bus.pc_in = pc;
      bus.inst_req_in = 1'b1;
      exp_q.push_back(exp_word);
      for (int c = 0; c < 60 && !got; c++) begin
         if (c != 0) @(negedge clk_in);
         #1;
         if (bus.inst_ready_out) got = 1'b1;
         else begin
            if (c == 0) missed = 1'b1;
            if (bus.inst_out !== 32'd0) inst_leak = 1'b1;
            if (bus.mem_rd_req_out !== bus.mem_busy_out) req_bad = 1'b1;
            if (bus.mem_busy_out) begin
               busy_n++;
               trace.push_back(bus.mem_a_out);
            end
         end
      end
      if (!got) begin
         check({name, " timeout"}, 32'd0, 32'd1);
         exp_q.delete();
      end else begin
         w = exp_q.pop_front();
         check({name, " word"}, bus.inst_out, w);
      end
      check({name, " miss"}, 32'(missed), 32'(exp_miss));
      if (exp_miss) begin
         check({name, " penalty"}, busy_n, exp_pen);
         for (int i = 0; i <= gdel; i++) exp_tr.push_back(32'd0);
         for (int k = 0; k < 4; k++) exp_tr.push_back(line_addr(pc) + 32'(k));
         exp_tr.push_back(32'd0);
         tr_ok = (trace.size() == exp_tr.size());
         if (tr_ok) foreach (trace[i]) if (trace[i] !== exp_tr[i]) tr_ok = 1'b0;
         check({name, " addr trace"}, 32'(tr_ok), 32'd1);
         check({name, " inst zero when idle"}, 32'(inst_leak), 32'd0);
         check({name, " req tracks busy"}, 32'(req_bad), 32'd0);
      end
      @(posedge clk_in);
      #1;
      bus.inst_req_in = 1'b0;
   endtask

   initial begin
      bit got;
      for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11);
      ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;

      vecs[0]  = '{32'h0000_0000, 0, 1'b1, 6, 32'h0010_0513};
      vecs[1]  = '{32'h0000_0000, 0, 1'b0, 0, 32'h0010_0513};
      vecs[2]  = '{32'h0000_0400, 0, 1'b1, 6, 32'h0};
      vecs[3]  = '{32'h0000_0400, 0, 1'b0, 0, 32'h0};
      vecs[4]  = '{32'h0000_0000, 0, 1'b1, 6, 32'h0010_0513};
      vecs[5]  = '{32'h0000_0008, 3, 1'b1, 9, 32'h0};
      vecs[6]  = '{32'h0000_0008, 0, 1'b0, 0, 32'h0};
      vecs[7]  = '{32'h0000_0000, 0, 1'b0, 0, 32'h0010_0513};
      vecs[8]  = '{32'h0000_1236, 0, 1'b1, 6, 32'h0};
      vecs[9]  = '{32'h0000_1234, 0, 1'b0, 0, 32'h0};
      vecs[10] = '{32'h0000_0404, 1, 1'b1, 7, 32'h0};
      vecs[11] = '{32'h0000_0404, 0, 1'b0, 0, 32'h0};
      for (int i = 2; i < 12; i++) if (vecs[i].pc[11:0] != 12'h0) vecs[i].word = ram_word(vecs[i].pc);
      vecs[2].word = ram_word(32'h400);
      vecs[3].word = ram_word(32'h400);

      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; grant_delay = 0;
      bus.pc_in = 32'h0; bus.inst_req_in = 1'b1;
      #1 rst_in = 1'b0;
      #1;
      check("reset inst_ready", 32'(bus.inst_ready_out), 32'd0);
      check("reset inst", bus.inst_out, 32'd0);
      check("reset busy", 32'(bus.mem_busy_out), 32'd0);
      check("reset rd_req", 32'(bus.mem_rd_req_out), 32'd0);
      check("reset mem_a", bus.mem_a_out, 32'd0);
`ifdef ICACHE_STAT_EN
      check("reset hit_cnt", hit_cnt_out, 32'd0);
      check("reset miss_cnt", miss_cnt_out, 32'd0);
`endif
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      bus.inst_req_in = 1'b0;

      for (int i = 0; i < 12; i++)
         do_fetch(vecs[i].pc, vecs[i].gdel, vecs[i].miss, vecs[i].pen, vecs[i].word, $sformatf("v%0d", i));

      // Flush while the third byte address is on the bus.
      grant_delay = 0;
      @(negedge clk_in);
      bus.pc_in = 32'h10; bus.inst_req_in = 1'b1;
      repeat (4) @(negedge clk_in);
      #1;
      check("clear cnt2 addr", bus.mem_a_out, 32'h12);
      check("clear req before", 32'(bus.mem_rd_req_out), 32'd1);
      clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0; bus.inst_req_in = 1'b0;
      #1;
      check("clear busy after", 32'(bus.mem_busy_out), 32'd0);
      check("clear req after", 32'(bus.mem_rd_req_out), 32'd0);
      do_fetch(32'h10, 0, 1'b1, 6, ram_word(32'h10), "refetch after clear");

      // Global stall in the middle of a fill.
      @(negedge clk_in);
      bus.pc_in = 32'h30; bus.inst_req_in = 1'b1;
      repeat (3) @(negedge clk_in);
      #1;
      check("stall addr before", bus.mem_a_out, 32'h31);
      rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         #1;
         check($sformatf("stall addr hold %0d", i), bus.mem_a_out, 32'h31);
      end
      rdy_in = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk_in);
         #1;
         if (bus.inst_ready_out) got = 1'b1;
      end
      check("stall fill done", 32'(got), 32'd1);
      if (got) check("stall fill word", bus.inst_out, ram_word(32'h30));
      @(posedge clk_in);
      #1 bus.inst_req_in = 1'b0;

      // Asynchronous reset in the middle of a fill.
      @(negedge clk_in);
      bus.pc_in = 32'h50; bus.inst_req_in = 1'b1;
      repeat (3) @(negedge clk_in);
      #1;
      check("pre-reset busy", 32'(bus.mem_busy_out), 32'd1);
      bus.pc_in = 32'h0;
      #1;
      check("pre-reset hit", 32'(bus.inst_ready_out), 32'd1);
      rst_in = 1'b0;
      #1;
      check("midfill reset ready", 32'(bus.inst_ready_out), 32'd0);
      check("midfill reset inst", bus.inst_out, 32'd0);
      check("midfill reset busy", 32'(bus.mem_busy_out), 32'd0);
      check("midfill reset rd_req", 32'(bus.mem_rd_req_out), 32'd0);
      check("midfill reset mem_a", bus.mem_a_out, 32'd0);
`ifdef ICACHE_STAT_EN
      check("midfill reset hit_cnt", hit_cnt_out, 32'd0);
      check("midfill reset miss_cnt", miss_cnt_out, 32'd0);
`endif
      @(negedge clk_in);
      rst_in = 1'b1; bus.inst_req_in = 1'b0;

      // Three misses (each ending in one hit cycle) plus two plain hits.
      do_fetch(32'h0,   0, 1'b1, 6, 32'h0010_0513,      "post-reset 0x0");
      do_fetch(32'h0,   0, 1'b0, 0, 32'h0010_0513,      "post-reset 0x0 hit");
      do_fetch(32'h400, 0, 1'b1, 6, ram_word(32'h400), "post-reset 0x400");
      do_fetch(32'h400, 0, 1'b0, 0, ram_word(32'h400), "post-reset 0x400 hit");
      do_fetch(32'h8,   0, 1'b1, 6, ram_word(32'h8),   "post-reset 0x8");
`ifdef ICACHE_STAT_EN
      check("stat miss_cnt", miss_cnt_out, 32'd3);
      check("stat hit_cnt", hit_cnt_out, 32'd5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
